data_split_rd: RTL and testbench
================================

Name: data_split_rd

Overview:
- Read-side counterpart of the 6-lane merge path.
- Accepts 192-bit merged AXI-Stream beats, e.g. from the DDR/DMA read FIFO, and splits each beat into six independent 32-bit AXI-Stream lanes toward the DAC-side consumers.
- Each lane drains at its own pace.
- A new merged beat is taken only once every enabled lane has consumed its slice of the current beat.
- Lane N carries bits [32N+31:32N].

Parameters:
- LANES, 6, number of output lanes (fixed at 6 for port list; used for loops/masks).
- LANE_W, 32, bits per lane.
- MERGE_W, 192, merged width; must equal LANES*LANE_W.

Ports:
- axis_aclk  input  1  sole clock.
- axis_rstb  input  1  asynchronous active-low reset.
- lane_en  input  6  per-lane enable; sampled only when a merged beat is loaded.
- axis_tvalid_merge  input  1  merged beat valid.
- axis_tready_merge  output  1  merged beat ready.
- axis_tdata_merge  input  192  merged beat data.
- axis_tvalid_N  output  1  lane N valid (N=0..5).
- axis_tready_N  input  1  lane N ready (N=0..5).
- axis_tdata_N  output  32  lane N data (N=0..5).

Behaviour:
- Reset (async assert, sync release):
  - pending[5:0]=0; all axis_tvalid_N=0; axis_tdata_N=0; axis_tready_merge=0 while axis_rstb low.
  - Optional counters =0.
- State:
  - pending[5:0]: lanes still owing their slice of the current beat.
  - lane_data registers: 6x32 bits.
- Definitions:
  - fire_N = axis_tvalid_N & axis_tready_N.
  - remain = pending & ~fire.
- Ready rule: axis_tready_merge = (remain == 0), out of reset. Combinational from lane readies; no dependency on axis_tvalid_merge.
- Load: on axis_tvalid_merge & axis_tready_merge at a rising edge:
  - lane_data[N] <= axis_tdata_merge[32N+:32] for all N.
  - pending <= lane_en.
- Drain: otherwise pending <= remain.
- Output mapping: axis_tvalid_N = pending[N]; axis_tdata_N = lane_data[N].
- Latency: 1 cycle from merged handshake to lane valids.
- Throughput: with all lanes ready, one merged beat per cycle (last-lane fire and next load happen in the same cycle).
- AXIS rules:
  - Once asserted, axis_tvalid_N and axis_tdata_N hold stable until fire_N.
  - Lanes never re-present a slice.
  - No lane valid is dropped by a merged-side event.
- Boundary conditions:
  - Disabled lane: its slice is discarded at load and axis_tvalid_N stays 0 for that beat.
  - lane_en == 0: every merged beat is accepted and dropped; axis_tready_merge stays 1.
  - lane_en change mid-beat: no effect on the current pending mask; applies at next load only.
  - Slow lane: blocks the merged input. Other lanes that have completed idle with tvalid=0 and do not receive the next beat early.
  - Reset mid-beat: pending cleared immediately (async); partially delivered beat is lost; no lane valid after reset release until a new load.
  - axis_tvalid_merge with tready=0: no state change.

Optional Feature:
- DATA_SPLIT_STATS_EN.
- Defined: adds outputs stat_beats (32-bit, merged beats accepted) and stat_stall (32-bit, cycles with axis_tvalid_merge=1 & axis_tready_merge=0).
  - Both wrap modulo 2^32.
  - Both reset to 0 on axis_rstb.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package data_split_pkg:
  - LANES, LANE_W, MERGE_W localparams.
  - lane_mask_t typedef (logic [LANES-1:0]).
  - Function to slice lane N from a merged word.
- Sub-module split_lane_reg, instantiated 6x:
  - Holds one lane's data register and pending bit.
  - Inputs: load, en, din, tready. Outputs: tvalid, tdata, remain.
- Top level:
  - ANDs/ORs the remain bits into axis_tready_merge.
  - Hosts the optional counters.

Test Plan:
- Reset release, all lanes ready, lane_en=6'h3F, merged beats 0x...0005_0004_0003_0002_0001_0000 then +0x6 per lane:
  - Lane N shows N, then N+6, on consecutive cycles.
  - axis_tready_merge held 1.
  - 1-cycle latency.
- Lane 3 tready held 0 for 5 cycles after load, others ready:
  - Lanes 0-2,4,5 fire once and go idle.
  - axis_tready_merge=0 for those 5 cycles.
  - Next beat loads in the cycle lane 3 fires.
  - Lane 3 data stable throughout.
- lane_en=6'b010101, 3 beats:
  - Only lanes 0, 2, 4 assert valid.
  - Lanes 1, 3, 5 never valid.
  - lane_en switched to 6'h3F mid-beat affects only the following beat.
- lane_en=0, 10 merged beats back-to-back:
  - All accepted in 10 cycles.
  - No lane valid.
  - stat_beats=10 if DATA_SPLIT_STATS_EN.
- axis_rstb pulsed low while pending=6'b100100:
  - All valids drop asynchronously.
  - axis_tready_merge=0 during reset, then 1.
  - No stale slice emitted afterwards.
- DATA_SPLIT_STATS_EN: hold lane 0 not-ready 7 cycles with merged valid high → stat_stall=7; stat_beats preset to 0xFFFFFFFF wraps to 0 on next accept.

Source files
------------

// File: rtl/data_split_pkg.sv
// data_split_pkg: shared widths, lane mask type and slice helper for the merged-beat read splitter.
package data_split_pkg;
  localparam int LANES   = 6;
  localparam int LANE_W  = 32;
  localparam int MERGE_W = LANES * LANE_W;

  typedef logic [LANES-1:0] lane_mask_t;

  function automatic logic [LANE_W-1:0] lane_slice(input logic [MERGE_W-1:0] word, input int n);
    return word[n*LANE_W +: LANE_W];
  endfunction
endpackage

// File: rtl/split_lane_reg.sv
// split_lane_reg: one output lane's data register and pending bit.
module split_lane_reg
  import data_split_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_en,
  input  logic [LANE_W-1:0] i_din,
  input  logic              i_tready,
  output logic              o_tvalid,
  output logic [LANE_W-1:0] o_tdata,
  output logic              o_remain
);
  logic              r_pending;
  logic [LANE_W-1:0] r_data;

  assign o_remain = r_pending & ~i_tready;
  assign o_tvalid = r_pending;
  assign o_tdata  = r_data;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_pending <= 1'b0;
      r_data    <= '0;
    end else if (i_load) begin
      r_pending <= i_en;
      r_data    <= i_din;
    end else begin
      r_pending <= o_remain;
    end
endmodule

// File: rtl/data_split_rd.sv
// data_split_rd: splits 192-bit merged AXI-Stream beats into six independently drained 32-bit lanes.
// Define DATA_SPLIT_STATS_EN to add the stat_beats / stat_stall counters.
module data_split_rd
  import data_split_pkg::*;
(
  input  logic               axis_aclk,
  input  logic               axis_rstb,
  input  lane_mask_t         lane_en,
  input  logic               axis_tvalid_merge,
  output logic               axis_tready_merge,
  input  logic [MERGE_W-1:0] axis_tdata_merge,
  output logic               axis_tvalid_0,
  input  logic               axis_tready_0,
  output logic [LANE_W-1:0]  axis_tdata_0,
  output logic               axis_tvalid_1,
  input  logic               axis_tready_1,
  output logic [LANE_W-1:0]  axis_tdata_1,
  output logic               axis_tvalid_2,
  input  logic               axis_tready_2,
  output logic [LANE_W-1:0]  axis_tdata_2,
  output logic               axis_tvalid_3,
  input  logic               axis_tready_3,
  output logic [LANE_W-1:0]  axis_tdata_3,
  output logic               axis_tvalid_4,
  input  logic               axis_tready_4,
  output logic [LANE_W-1:0]  axis_tdata_4,
  output logic               axis_tvalid_5,
  input  logic               axis_tready_5,
  output logic [LANE_W-1:0]  axis_tdata_5
`ifdef DATA_SPLIT_STATS_EN
  ,
  output logic [31:0]        stat_beats,
  output logic [31:0]        stat_stall
`endif
);
  lane_mask_t        w_tready, w_tvalid, w_remain;
  logic [LANE_W-1:0] w_tdata [LANES];
  logic              w_load;

  assign w_tready = {axis_tready_5, axis_tready_4, axis_tready_3,
                     axis_tready_2, axis_tready_1, axis_tready_0};
  // Gated by reset so the merged side never sees ready while held in reset.
  assign axis_tready_merge = axis_rstb & ~|w_remain;
  assign w_load = axis_tvalid_merge & axis_tready_merge;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    split_lane_reg u_lane (
      .i_clk    (axis_aclk),
      .i_rst_n  (axis_rstb),
      .i_load   (w_load),
      .i_en     (lane_en[n]),
      .i_din    (lane_slice(axis_tdata_merge, n)),
      .i_tready (w_tready[n]),
      .o_tvalid (w_tvalid[n]),
      .o_tdata  (w_tdata[n]),
      .o_remain (w_remain[n])
    );
  end

  assign {axis_tvalid_5, axis_tvalid_4, axis_tvalid_3,
          axis_tvalid_2, axis_tvalid_1, axis_tvalid_0} = w_tvalid;
  assign axis_tdata_0 = w_tdata[0];
  assign axis_tdata_1 = w_tdata[1];
  assign axis_tdata_2 = w_tdata[2];
  assign axis_tdata_3 = w_tdata[3];
  assign axis_tdata_4 = w_tdata[4];
  assign axis_tdata_5 = w_tdata[5];

`ifdef DATA_SPLIT_STATS_EN
  logic [31:0] r_stat_beats, r_stat_stall;

  always_ff @(posedge axis_aclk or negedge axis_rstb)
    if (!axis_rstb) begin
      r_stat_beats <= '0;
      r_stat_stall <= '0;
    end else begin
      r_stat_beats <= r_stat_beats + 32'(w_load);
      r_stat_stall <= r_stat_stall + 32'(axis_tvalid_merge & ~axis_tready_merge);
    end

  assign stat_beats = r_stat_beats;
  assign stat_stall = r_stat_stall;
`endif
endmodule

// File: tb/tb_data_split_rd.sv
// tb_data_split_rd: scoreboard bench for data_split_rd; per-lane expected-slice queues fed on merged accepts.
module tb_data_split_rd;
  logic         clk = 1'b0;
  logic         rstb;
  logic [5:0]   en;
  logic         vm;
  logic         rm;
  logic [191:0] dm;
  logic [5:0]   tv;
  logic [5:0]   tr;
  logic [31:0]  td [6];
  logic [31:0]  sb [6][$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           n_acc = 0;
  int           n_stall = 0;
`ifdef DATA_SPLIT_STATS_EN
  logic [31:0]  stat_beats, stat_stall;
`endif

  always #5 clk = ~clk;

  data_split_rd dut (
    .axis_aclk(clk), .axis_rstb(rstb), .lane_en(en),
    .axis_tvalid_merge(vm), .axis_tready_merge(rm), .axis_tdata_merge(dm),
    .axis_tvalid_0(tv[0]), .axis_tready_0(tr[0]), .axis_tdata_0(td[0]),
    .axis_tvalid_1(tv[1]), .axis_tready_1(tr[1]), .axis_tdata_1(td[1]),
    .axis_tvalid_2(tv[2]), .axis_tready_2(tr[2]), .axis_tdata_2(td[2]),
    .axis_tvalid_3(tv[3]), .axis_tready_3(tr[3]), .axis_tdata_3(td[3]),
    .axis_tvalid_4(tv[4]), .axis_tready_4(tr[4]), .axis_tdata_4(td[4]),
    .axis_tvalid_5(tv[5]), .axis_tready_5(tr[5]), .axis_tdata_5(td[5])
`ifdef DATA_SPLIT_STATS_EN
    , .stat_beats(stat_beats), .stat_stall(stat_stall)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [191:0] beat(input int k);
    logic [191:0] w;
    for (int n = 0; n < 6; n++) w[n*32 +: 32] = 32'(k*6 + n);
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: any valid lane must present the oldest outstanding slice; accepts enqueue enabled slices.
  always @(negedge clk) begin
    if (rstb) begin
      for (int i = 0; i < 6; i++)
        if (tv[i]) begin
          if (sb[i].size() == 0) chk($sformatf("unexpected_valid_lane%0d", i), 32'(tv[i]), 32'd0);
          else begin
            chk($sformatf("lane%0d_data", i), td[i], sb[i][0]);
            if (tr[i]) void'(sb[i].pop_front());
          end
        end
      if (vm && rm) begin
        n_acc++;
        for (int i = 0; i < 6; i++) if (en[i]) sb[i].push_back(dm[i*32 +: 32]);
      end
      if (vm && !rm) n_stall++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstb = 1'b0; en = 6'h3F; vm = 1'b0; dm = '0; tr = 6'h3F;
    #1;
    chk("reset_ready", 32'(rm), 32'd0);
    chk("reset_valid", 32'(tv), 32'd0);
    repeat (2) step();
    rstb = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", 32'(rm), 32'd1);
    step();
    // Full-rate streaming with all lanes ready
    vm = 1'b1;
    dm = beat(0);
    step();
    dm = beat(1);
    @(negedge clk);
    chk("latency_valid", 32'(tv), 32'h3F);
    chk("latency_lane3", td[3], 32'd3);
    for (int k = 2; k < 5; k++) begin
      chk("stream_ready", 32'(rm), 32'd1);
      step();
      dm = beat(k);
    end
    vm = 1'b0;
    repeat (2) step();
    // Slow lane 3
    tr = 6'h37;
    vm = 1'b1;
    dm = beat(10);
    step();
    dm = beat(11);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("slow_ready", 32'(rm), 32'd0);
      if (c > 0) chk("slow_idle", 32'(tv), 32'h08);
      step();
    end
    tr = 6'h3F;
    @(negedge clk);
    chk("slow_release_ready", 32'(rm), 32'd1);
    step();
    vm = 1'b0;
    @(negedge clk);
    chk("slow_next_beat", 32'(tv), 32'h3F);
    repeat (2) step();
    // Partial enable, mask change mid-beat
    en = 6'b010101;
    vm = 1'b1;
    for (int k = 0; k < 3; k++) begin
      dm = beat(20 + k);
      step();
    end
    tr = 6'h00;
    dm = beat(23);
    step();
    vm = 1'b0;
    en = 6'h3F;
    @(negedge clk);
    chk("en_mid_beat_valid", 32'(tv), 32'h15);
    step();
    tr = 6'h3F;
    vm = 1'b1;
    dm = beat(24);
    step();
    vm = 1'b0;
    @(negedge clk);
    chk("en_next_beat_valid", 32'(tv), 32'h3F);
    repeat (2) step();
    // All lanes disabled: every beat swallowed at full rate
    en = 6'h00;
    vm = 1'b1;
    for (int k = 0; k < 10; k++) begin
      dm = beat(30 + k);
      @(negedge clk);
      chk("drop_ready", 32'(rm), 32'd1);
      chk("drop_valid", 32'(tv), 32'd0);
      step();
    end
    vm = 1'b0;
`ifdef DATA_SPLIT_STATS_EN
    @(negedge clk);
    chk("stat_beats", stat_beats, 32'(n_acc));
    step();
`endif
    // Reset mid-beat with lanes 2 and 5 still pending
    en = 6'h3F;
    tr = 6'b011011;
    vm = 1'b1;
    dm = beat(40);
    step();
    vm = 1'b0;
    @(negedge clk);
    chk("pre_reset_valid", 32'(tv), 32'h3F);
    @(posedge clk);
    #2;
    chk("pending_mask", 32'(tv), 32'h24);
    rstb = 1'b0;
    #1;
    chk("async_valid_drop", 32'(tv), 32'd0);
    chk("reset_ready_low", 32'(rm), 32'd0);
    for (int i = 0; i < 6; i++) sb[i].delete();
    n_acc = 0;
    n_stall = 0;
    step();
    rstb = 1'b1;
    tr = 6'h3F;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_reset_idle", 32'(tv), 32'd0);
      chk("post_reset_ready2", 32'(rm), 32'd1);
      step();
    end
`ifdef DATA_SPLIT_STATS_EN
    // Stall counting with lane 0 held off
    tr = 6'h3E;
    vm = 1'b1;
    dm = beat(50);
    step();
    dm = beat(51);
    repeat (7) step();
    vm = 1'b0;
    tr = 6'h3F;
    @(negedge clk);
    chk("stat_stall", stat_stall, 32'(n_stall));
    chk("stat_stall_7", stat_stall, 32'd7);
    chk("stat_beats_after_reset", stat_beats, 32'(n_acc));
    step();
`endif
    repeat (3) step();
    for (int i = 0; i < 6; i++) chk($sformatf("drain_lane%0d", i), 32'(sb[i].size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
